// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants and the writeback-controller state type.
package rv32i_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef logic [0:0] wbctrl_state_t;
   localparam wbctrl_state_t INIT = 1'b0;
   localparam wbctrl_state_t RUN  = 1'b1;

endpackage

// File: rtl/regfile_wb_ctrl_wb_arbiter.sv
// Writeback requester arbiter: one-hot grant among valid requesters.
// RF_WB_RR_EN selects round-robin from ptr; otherwise lowest index wins.
module wb_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
`ifdef RF_WB_RR_EN
   input  logic [PW-1:0]   ptr,
`endif
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx
);

`ifdef RF_WB_RR_EN
   function automatic int unsigned wrap(input int unsigned a);
      return (a >= NREQ) ? a - NREQ : a;
   endfunction

   // Scan from the pointer, wrapping, and take the first valid requester.
   always_comb begin
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         if (!found && valid[wrap(32'(ptr) + off)]) begin
            grant[wrap(32'(ptr) + off)] = 1'b1;
            grant_idx = PW'(wrap(32'(ptr) + off));
            found     = 1'b1;
         end
      end
   end
`else
   always_comb begin
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && valid[i]) begin
            grant[i]  = 1'b1;
            grant_idx = PW'(i);
            found     = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: zero-sweeps all entries after reset, then
// arbitrates writeback requesters onto the port. RF_WB_RR_EN enables round-robin.
module regfile_wb_ctrl
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN_P = XLEN,
   parameter int unsigned NREQ   = 2,
   parameter int unsigned AW     = REG_AW,
   parameter int unsigned GW     = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*XLEN_P-1:0] req_data,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_addr,
   output logic [XLEN_P-1:0]    rf_d,
   output logic                 init_done,
   output logic [GW-1:0]        grant_id
);

   localparam int unsigned NREGS = 1 << AW;

   wbctrl_state_t     state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic              we_d, done_d;
   logic [AW-1:0]     addr_d;
   logic [XLEN_P-1:0] d_d;
   logic [GW-1:0]     gid_d;
   logic [NREQ-1:0]   grant;
   logic [GW-1:0]     win;
   logic [AW-1:0]     sel_addr;
   logic [XLEN_P-1:0] sel_data;
   logic              xfer;

`ifdef RF_WB_RR_EN
   logic [GW-1:0]     rr_ptr, ptr_d;

   wb_arbiter #(.NREQ(NREQ), .PW(GW)) u_arb (
      .valid     (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (win)
   );
`else
   wb_arbiter #(.NREQ(NREQ), .PW(GW)) u_arb (
      .valid     (req_valid),
      .grant     (grant),
      .grant_idx (win)
   );
`endif

   // Accept only once the sweep has fully retired, so the first RUN cycle never writes.
   assign req_ready = (state_q == RUN && init_done) ? grant : '0;
   assign xfer      = |req_ready;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = sel_addr | req_addr[i*AW +: AW];
            sel_data = sel_data | req_data[i*XLEN_P +: XLEN_P];
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= INIT;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = rf_addr;
      d_d     = rf_d;
      gid_d   = grant_id;
      done_d  = init_done;
`ifdef RF_WB_RR_EN
      ptr_d   = rr_ptr;
`endif
      case (state_q)
         INIT: begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            d_d    = '0;
            cnt_d  = cnt_q + AW'(1);
            if (cnt_q == AW'(NREGS - 1)) state_d = RUN;
         end
         default: begin
            done_d = 1'b1;
            if (xfer) begin
`ifdef RF_WB_RR_EN
               ptr_d = (win == GW'(NREQ - 1)) ? '0 : win + GW'(1);
`endif
               // x0 writes complete the handshake but never reach the port.
               if (sel_addr != AW'(REG_ZERO)) begin
                  we_d   = 1'b1;
                  addr_d = sel_addr;
                  d_d    = sel_data;
                  gid_d  = win;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q     <= '0;
         rf_we     <= 1'b0;
         rf_addr   <= '0;
         rf_d      <= '0;
         init_done <= 1'b0;
         grant_id  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         rf_we     <= we_d;
         rf_addr   <= addr_d;
         rf_d      <= d_d;
         init_done <= done_d;
         grant_id  <= gid_d;
      end
   end

`ifdef RF_WB_RR_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) rr_ptr <= '0;
      else      rr_ptr <= ptr_d;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: reset sweep, random writeback traffic, mid-sweep reset.
module tb_regfile_wb_ctrl;

   localparam int unsigned NREQ = 3;
   localparam int unsigned AW   = 5;
   localparam int unsigned XL   = 32;
   localparam int unsigned GW   = $clog2(NREQ);

   logic                 clk = 1'b0;
   logic                 clr;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*XL-1:0]   req_data;
   logic                 rf_we;
   logic [AW-1:0]        rf_addr;
   logic [XL-1:0]        rf_d;
   logic                 init_done;
   logic [GW-1:0]        grant_id;

   regfile_wb_ctrl #(.NREQ(NREQ)) dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_d(rf_d),
      .init_done(init_done), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      int          gid;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        mon_en = 1'b0;
   int          ptr;
   logic        pend [NREQ];
   logic        v    [NREQ];
   logic [4:0]  a    [NREQ];
   logic [31:0] dat  [NREQ];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: round-robin from ptr or lowest index.
   function automatic int pick();
`ifdef RF_WB_RR_EN
      for (int off = 0; off < NREQ; off++)
         if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
`else
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
`endif
      return -1;
   endfunction

   // Monitor: pops one expected port cycle after each clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (q.size() == 0) begin
               chk("queue_underflow", 64'(1), 64'(0));
            end else begin
               e = q.pop_front();
               chk("rf_we", 64'(rf_we), 64'(e.we));
               chk("init_done_run", 64'(init_done), 64'(1));
               if (e.we) begin
                  chk("rf_addr", 64'(rf_addr), 64'(e.addr));
                  chk("rf_d", 64'(rf_d), 64'(e.data));
                  chk("grant_id", 64'(grant_id), 64'(e.gid));
               end
            end
         end
      end
   end

   task automatic drive_pins();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]           = v[i];
         req_addr[i*AW +: AW]   = a[i];
         req_data[i*XL +: XL]   = dat[i];
      end
   endtask

   // Called at posedge+1; sweeps checked cycle by cycle after clr release.
   task automatic release_and_sweep();
      @(negedge clk);
      clr = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(posedge clk);
         #1;
         chk("sweep_we", 64'(rf_we), 64'(1));
         chk("sweep_addr", 64'(rf_addr), 64'(k));
         chk("sweep_d", 64'(rf_d), 64'(0));
         chk("sweep_ready", 64'(req_ready), 64'(0));
         chk("sweep_done", 64'(init_done), 64'(0));
      end
      @(posedge clk);
      #1;
      chk("done_rise", 64'(init_done), 64'(1));
      chk("done_we", 64'(rf_we), 64'(0));
   endtask

   task automatic run_random(input int ncyc);
      exp_t e;
      int   w;
      q.delete();
      ptr = 0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i]) begin
               v[i]   = ($urandom_range(0, 9) < 7);
               a[i]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               dat[i] = $urandom;
            end
         end
         drive_pins();
         #1;
         w = pick();
         chk("req_ready", 64'(req_ready), (w >= 0) ? (64'(1) << w) : 64'(0));
         e.we   = (w >= 0) && (a[(w >= 0) ? w : 0] != 5'd0);
         e.addr = (w >= 0) ? a[w] : 5'd0;
         e.data = (w >= 0) ? dat[w] : 32'd0;
         e.gid  = w;
         q.push_back(e);
         mon_en = 1'b1;
         for (int i = 0; i < NREQ; i++) pend[i] = v[i];
         if (w >= 0) begin
            pend[w] = 1'b0;
            ptr = (w + 1) % NREQ;
         end
         @(posedge clk);
         #1;
      end
      #1;
      mon_en = 1'b0;
      chk("queue_drained", 64'(q.size()), 64'(0));
      for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
      drive_pins();
   endtask

   initial begin
      clr       = 1'b0;
      req_valid = '1;
      req_addr  = '0;
      req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         v[i] = 1'b1; a[i] = 5'(i + 1); dat[i] = 32'hDEADBEEF;
      end
      drive_pins();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we", 64'(rf_we), 64'(0));
      chk("rst_addr", 64'(rf_addr), 64'(0));
      chk("rst_d", 64'(rf_d), 64'(0));
      chk("rst_done", 64'(init_done), 64'(0));
      chk("rst_gid", 64'(grant_id), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));

      release_and_sweep();
      run_random(400);

      // Reset at sweep count 10: outputs clear immediately, sweep restarts at 0.
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_addr", 64'(rf_addr), 64'(9));
      #1;
      clr = 1'b0;
      #1;
      chk("mid_rst_we", 64'(rf_we), 64'(0));
      chk("mid_rst_done", 64'(init_done), 64'(0));
      chk("mid_rst_addr", 64'(rf_addr), 64'(0));
      release_and_sweep();
      run_random(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
